// File: rtl/axi_arb_pkg.sv
// Shared definitions for the two-master AXI write-path arbiter.
//   arb_state_e     : burst-level FSM states
//   BRESP_*         : AXI write response codes used by the arbiter and its users
//   NUM_MASTERS     : number of upstream write masters
//   oh2idx()        : one-hot (2-bit) grant to master index
package axi_arb_pkg;

  localparam int NUM_MASTERS = 2;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } arb_state_e;

  // Only meaningful for a one-hot or zero vector; zero maps to master 0.
  function automatic logic oh2idx(input logic [NUM_MASTERS-1:0] oh);
    return oh[1];
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Two-input round-robin selector.
//   req_i : request vector, one bit per requester
//   ptr_i : index of the requester that currently holds priority
//   gnt_o : one-hot winner, zero when nothing is requested
// Pure combinational; the caller owns the pointer register and decides
// when to move it.
module rr_pick (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);

  logic alt;
  assign alt = ~ptr_i;

  always_comb begin
    gnt_o = 2'b00;
    if (req_i[ptr_i])    gnt_o[ptr_i] = 1'b1;
    else if (req_i[alt]) gnt_o[alt]   = 1'b1;
  end

endmodule

// File: rtl/axi_write_arbiter.sv
// Shares one AXI4 write path (AW, W, B) between two write masters. A master
// owns the path for a whole burst, from the address handshake to the write
// response; ownership alternates round-robin at burst granularity.
//
// Ports
//   clk, ARESET            : clock, synchronous active-high reset
//   m_AW*/m_W*/m_B*        : per-master AXI write channels (index = master)
//   s_AW*/s_W*/s_B*        : single slave-side AXI write channels
//   grant                  : one-hot current owner, 2'b00 while idle
//   wlast_err              : sticky flag, WLAST disagreed with AWLEN
//
// All master<->slave channel paths are combinational muxes selected by the
// registered grant and the FSM state, so there is no per-beat latency.
module axi_write_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                     clk,
  input  logic                                     ARESET,
  // master side
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]   m_AWADDR,
  input  logic [NUM_MASTERS-1:0][7:0]              m_AWLEN,
  input  logic [NUM_MASTERS-1:0][2:0]              m_AWSIZE,
  input  logic [NUM_MASTERS-1:0]                   m_AWVALID,
  output logic [NUM_MASTERS-1:0]                   m_AWREADY,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]   m_WDATA,
  input  logic [NUM_MASTERS-1:0]                   m_WLAST,
  input  logic [NUM_MASTERS-1:0]                   m_WVALID,
  output logic [NUM_MASTERS-1:0]                   m_WREADY,
  output logic [NUM_MASTERS-1:0][1:0]              m_BRESP,
  output logic [NUM_MASTERS-1:0]                   m_BVALID,
  input  logic [NUM_MASTERS-1:0]                   m_BREADY,
  // slave side
  output logic [ADDR_WIDTH-1:0]                    s_AWADDR,
  output logic [7:0]                               s_AWLEN,
  output logic [2:0]                               s_AWSIZE,
  output logic                                     s_AWVALID,
  input  logic                                     s_AWREADY,
  output logic [DATA_WIDTH-1:0]                    s_WDATA,
  output logic                                     s_WLAST,
  output logic                                     s_WVALID,
  input  logic                                     s_WREADY,
  input  logic [1:0]                               s_BRESP,
  input  logic                                     s_BVALID,
  output logic                                     s_BREADY,
  // status
  output logic [NUM_MASTERS-1:0]                   grant,
  output logic                                     wlast_err
);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic                   ptr_q, ptr_d;      // master holding priority
  logic [7:0]             len_q, len_d;
  logic [7:0]             beat_q, beat_d;
  logic                   err_q, err_d;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic                   g;                 // owner index
  logic                   aw_hs, w_hs, b_hs;

  assign g = oh2idx(grant_q);

  rr_pick u_pick (
    .req_i (m_AWVALID),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt)
  );

  // ---------------------------------------------------------------------
  // Channel muxes: each channel is only connected while the FSM is in the
  // matching phase; everything else is held at zero.
  // ---------------------------------------------------------------------
  always_comb begin
    m_AWREADY = '0;
    m_WREADY  = '0;
    m_BVALID  = '0;
    m_BRESP   = '0;
    s_AWADDR  = '0;
    s_AWLEN   = '0;
    s_AWSIZE  = '0;
    s_AWVALID = 1'b0;
    s_WDATA   = '0;
    s_WLAST   = 1'b0;
    s_WVALID  = 1'b0;
    s_BREADY  = 1'b0;
    unique case (state_q)
      ADDR: begin
        s_AWADDR     = m_AWADDR[g];
        s_AWLEN      = m_AWLEN[g];
        s_AWSIZE     = m_AWSIZE[g];
        s_AWVALID    = m_AWVALID[g];
        m_AWREADY[g] = s_AWREADY;
      end
      DATA: begin
        s_WDATA     = m_WDATA[g];
        s_WLAST     = m_WLAST[g];
        s_WVALID    = m_WVALID[g];
        m_WREADY[g] = s_WREADY;
      end
      RESP: begin
        m_BVALID[g] = s_BVALID;
        m_BRESP[g]  = s_BRESP;
        s_BREADY    = m_BREADY[g];
      end
      default: ;
    endcase
  end

  assign aw_hs = s_AWVALID && s_AWREADY;
  assign w_hs  = s_WVALID  && s_WREADY;
  assign b_hs  = s_BVALID  && s_BREADY;

  // ---------------------------------------------------------------------
  // Burst FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (|m_AWVALID) begin
          grant_d = pick_gnt;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (aw_hs) begin
          len_d   = m_AWLEN[g];
          beat_d  = 8'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (w_hs) begin
          beat_d = beat_q + 8'd1;
          // WLAST must coincide exactly with the beat AWLEN predicts; a
          // mismatch is only flagged, the burst still ends on WLAST.
          if (m_WLAST[g] != (beat_q == len_q)) err_d = 1'b1;
          if (m_WLAST[g]) state_d = RESP;
        end
      end
      RESP: begin
        if (b_hs) begin
          ptr_d   = ~g;
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ARESET) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= 1'b0;
      len_q   <= 8'd0;
      beat_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  assign grant     = grant_q;
  assign wlast_err = err_q;

endmodule
